audio_sram_scheduler: RTL and testbench

//  Sequences song playback out of the shared 16-bit SRAM and feeds the audio codec interface.
//  On each codec sample request (adc_full) it fetches the next song word and presents it on LDATA/RDATA.
//  It arbitrates the SRAM between that audio fetch and one general read port (sprite/frame reader).

---
 rtl/audio_sram_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_audio_sram_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sram_scheduler.sv
// rtl/audio_sram_scheduler.sv - song playback fetcher and SRAM read arbiter for the audio codec
//
// Purpose: on each codec sample strobe (adc_full, asynchronous) fetch the next
// song word from the shared 16-bit SRAM and present it on LDATA/RDATA, while
// sharing the SRAM with one general read port. Audio fetches win arbitration.
//
// Ports:
//   clk, Reset              clock, asynchronous active-low reset
//   INIT_FINISH             codec init complete; sample strobes ignored until set
//   adc_full                codec sample strobe (async, rising edge = request)
//   play, stop              1-cycle playback control pulses (stop wins)
//   rd_req, rd_addr         general read request (level) and word address
//   rd_ack, rd_data         1-cycle completion pulse and read data
//   SRAM_ADDR, SRAM_OE_N    SRAM address and active-low output enable
//   SRAM_DQ                 SRAM read data
//   LDATA, RDATA            mono sample to codec (identical)
//   playing                 playback active
//   song_done               1-cycle pulse when the last song word is fetched
//   overrun                 sticky: sample request arrived while one was pending
module audio_sram_scheduler #(
  parameter int                ADDR_W     = 20,
  parameter logic [ADDR_W-1:0] SONG_START = 20'h00000,
  parameter logic [ADDR_W-1:0] SONG_END   = 20'h3FFFF,
  parameter int                RD_LAT     = 2,
  parameter bit                LOOP       = 1'b1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              INIT_FINISH,
  input  logic              adc_full,
  input  logic              play,
  input  logic              stop,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [15:0]       rd_data,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_OE_N,
  input  logic [15:0]       SRAM_DQ,
  output logic [15:0]       LDATA,
  output logic [15:0]       RDATA,
  output logic              playing,
  output logic              song_done,
  output logic              overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_AUD_RD, ST_GEN_RD} state_t;

  localparam logic [2:0]        LAT_M1   = 3'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] PTR_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] ptr;
  logic              pend;
  logic              aud_live;   // in-flight audio read still wanted (not cancelled by play/stop)
  logic              adc_s1, adc_s2, adc_s3;

  logic sreq, sreq_ok, aud_req, last_beat;
  logic grant_aud, grant_gen, done_aud, done_gen;

  assign sreq      = adc_s2 & ~adc_s3;
  assign sreq_ok   = sreq & playing & INIT_FINISH;
  // A fresh strobe is granted in the same cycle it is seen so audio beats a
  // general request raised alongside it. No grant while play/stop rewrites state.
  assign aud_req   = (pend | sreq_ok) & ~play & ~stop;
  assign last_beat = (cnt == LAT_M1);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_aud = 1'b0;
    grant_gen = 1'b0;
    done_aud  = 1'b0;
    done_gen  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (aud_req) begin
          state_nxt = ST_AUD_RD;
          grant_aud = 1'b1;
        end else if (rd_req) begin
          state_nxt = ST_GEN_RD;
          grant_gen = 1'b1;
        end
      end
      ST_AUD_RD: begin
        if (last_beat) begin
          state_nxt = ST_IDLE;
          done_aud  = 1'b1;
        end
      end
      ST_GEN_RD: begin
        if (last_beat) begin
          state_nxt = ST_IDLE;
          done_gen  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      adc_s1    <= 1'b0;
      adc_s2    <= 1'b0;
      adc_s3    <= 1'b0;
      cnt       <= 3'd0;
      ptr       <= SONG_START;
      pend      <= 1'b0;
      aud_live  <= 1'b0;
      rd_ack    <= 1'b0;
      rd_data   <= 16'h0000;
      SRAM_ADDR <= '0;
      SRAM_OE_N <= 1'b1;
      LDATA     <= 16'h0000;
      RDATA     <= 16'h0000;
      playing   <= 1'b0;
      song_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      adc_s1    <= adc_full;
      adc_s2    <= adc_s1;
      adc_s3    <= adc_s2;
      rd_ack    <= 1'b0;
      song_done <= 1'b0;

      if (grant_aud || grant_gen)  cnt <= 3'd0;
      else if (state != ST_IDLE)   cnt <= cnt + 3'd1;

      if (grant_aud) begin
        SRAM_ADDR <= ptr;
        SRAM_OE_N <= 1'b0;
        aud_live  <= 1'b1;
      end
      if (grant_gen) begin
        SRAM_ADDR <= rd_addr;
        SRAM_OE_N <= 1'b0;
      end
      if (done_aud || done_gen) SRAM_OE_N <= 1'b1;

      if (done_gen) begin
        rd_data <= SRAM_DQ;
        rd_ack  <= 1'b1;
      end

      // pend stays set through the audio read so a second strobe before
      // completion is recognised as an overrun.
      if (sreq_ok) begin
        pend <= 1'b1;
        if (pend) overrun <= 1'b1;
      end else if (done_aud) begin
        pend <= 1'b0;
      end

      if (done_aud) aud_live <= 1'b0;
      if (done_aud && aud_live) begin
        LDATA <= SRAM_DQ;
        RDATA <= SRAM_DQ;
        if (ptr == SONG_END) begin
          song_done <= 1'b1;
          if (LOOP) begin
            ptr <= SONG_START;
          end else begin
            playing <= 1'b0;
            pend    <= 1'b0;
          end
        end else begin
          ptr <= ptr + PTR_STEP;
        end
      end

      // Control pulses override everything above; a read already on the bus
      // finishes but its data is dropped via aud_live.
      if (play && !stop) begin
        playing  <= 1'b1;
        ptr      <= SONG_START;
        pend     <= 1'b0;
        aud_live <= 1'b0;
      end
      if (stop) begin
        playing  <= 1'b0;
        pend     <= 1'b0;
        aud_live <= 1'b0;
        LDATA    <= 16'h0000;
        RDATA    <= 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_audio_sram_scheduler.sv
// tb/tb_audio_sram_scheduler.sv - self-checking bench for audio_sram_scheduler
module tb_audio_sram_scheduler;

  logic        clk = 1'b0;
  logic        Reset, INIT_FINISH, adc_full, play, stop;
  logic        rd_req_a, rd_req_b;
  logic [19:0] rd_addr;

  logic        ack_a, oe_a, play_a, done_a, ovr_a;
  logic [15:0] rdd_a, ld_a, rr_a, dq_a;
  logic [19:0] addr_a;
  logic        ack_b, oe_b, play_b, done_b, ovr_b;
  logic [15:0] rdd_b, ld_b, rr_b, dq_b;
  logic [19:0] addr_b;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // Instance a: looping song of 4 words, RD_LAT=2
  audio_sram_scheduler #(.ADDR_W(20), .SONG_START(20'h0), .SONG_END(20'h3), .RD_LAT(2), .LOOP(1'b1)) u_dut_a (
    .clk(clk), .Reset(Reset), .INIT_FINISH(INIT_FINISH), .adc_full(adc_full),
    .play(play), .stop(stop), .rd_req(rd_req_a), .rd_addr(rd_addr),
    .rd_ack(ack_a), .rd_data(rdd_a), .SRAM_ADDR(addr_a), .SRAM_OE_N(oe_a),
    .SRAM_DQ(dq_a), .LDATA(ld_a), .RDATA(rr_a), .playing(play_a),
    .song_done(done_a), .overrun(ovr_a));

  // Instance b: one-shot song of 4 words, long reads (RD_LAT=7)
  audio_sram_scheduler #(.ADDR_W(20), .SONG_START(20'h0), .SONG_END(20'h3), .RD_LAT(7), .LOOP(1'b0)) u_dut_b (
    .clk(clk), .Reset(Reset), .INIT_FINISH(INIT_FINISH), .adc_full(adc_full),
    .play(play), .stop(stop), .rd_req(rd_req_b), .rd_addr(rd_addr),
    .rd_ack(ack_b), .rd_data(rdd_b), .SRAM_ADDR(addr_b), .SRAM_OE_N(oe_b),
    .SRAM_DQ(dq_b), .LDATA(ld_b), .RDATA(rr_b), .playing(play_b),
    .song_done(done_b), .overrun(ovr_b));

  // SRAM model: data only valid once OE_N has been low long enough
  function automatic logic [15:0] mem_word(input logic [19:0] a);
    return (a == 20'h80000) ? 16'hBEEF : (16'h1000 + a[15:0]);
  endfunction

  int low_a = 0;
  int low_b = 0;
  always @(posedge clk) begin
    low_a <= oe_a ? 0 : low_a + 1;
    low_b <= oe_b ? 0 : low_b + 1;
  end
  assign dq_a = (!oe_a && low_a >= 1) ? mem_word(addr_a) : 16'hDEAD;
  assign dq_b = (!oe_b && low_b >= 6) ? mem_word(addr_b) : 16'hDEAD;

  // Bus monitors: count audio fetches (OE_N falling on a song address), pulses
  logic        oe_a_q = 1'b1, oe_b_q = 1'b1;
  int          fetch_a = 0, fetch_b = 0, sd_a = 0, sd_b = 0, ackc_a = 0;
  logic [19:0] last_aud_a = 20'h0;
  always @(negedge clk) begin
    if (!oe_a && oe_a_q && addr_a != 20'h80000) begin
      fetch_a++;
      last_aud_a = addr_a;
    end
    if (!oe_b && oe_b_q && addr_b != 20'h80000) fetch_b++;
    oe_a_q = oe_a;
    oe_b_q = oe_b;
    if (done_a) sd_a++;
    if (done_b) sd_b++;
    if (ack_a)  ackc_a++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic sample_edge(input int hold);
    adc_full = 1'b1;
    tick(hold);
    adc_full = 1'b0;
    tick(3);
  endtask

  task automatic pulse_play();
    play = 1'b1;
    tick(1);
    play = 1'b0;
    tick(1);
  endtask

  typedef struct {
    logic [19:0] addr_a;
    logic [15:0] l_a;
    logic [15:0] l_b;
    logic        play_b;
    int          sd_a;
    int          sd_b;
    int          fetch_b;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, snap_a, snap_b, snap_ack;

    tbl[0] = '{20'h0, 16'h1000, 16'h1000, 1'b1, 0, 0, 1};
    tbl[1] = '{20'h1, 16'h1001, 16'h1001, 1'b1, 0, 0, 2};
    tbl[2] = '{20'h2, 16'h1002, 16'h1002, 1'b1, 0, 0, 3};
    tbl[3] = '{20'h3, 16'h1003, 16'h1003, 1'b0, 1, 1, 4};
    tbl[4] = '{20'h0, 16'h1000, 16'h1003, 1'b0, 1, 1, 4};

    Reset = 1'b0; INIT_FINISH = 1'b0; adc_full = 1'b0; play = 1'b0; stop = 1'b0;
    rd_req_a = 1'b0; rd_req_b = 1'b0; rd_addr = 20'h0;
    tick(3);

    chk("rst_ldata",   32'(ld_a),   32'h0);
    chk("rst_rdata",   32'(rr_a),   32'h0);
    chk("rst_rd_data", 32'(rdd_a),  32'h0);
    chk("rst_addr",    32'(addr_a), 32'h0);
    chk("rst_oe_n",    32'(oe_a),   32'h1);
    chk("rst_rd_ack",  32'(ack_a),  32'h0);
    chk("rst_playing", 32'(play_a), 32'h0);
    chk("rst_done",    32'(done_a), 32'h0);
    chk("rst_overrun", 32'(ovr_a),  32'h0);
    chk("rst_oe_n_b",  32'(oe_b),   32'h1);

    Reset = 1'b1; INIT_FINISH = 1'b1;
    tick(2);
    pulse_play();
    chk("play_a", 32'(play_a), 32'h1);
    chk("play_b", 32'(play_b), 32'h1);

    // Five sample edges across the song end: wrap on a, stop on b
    for (int i = 0; i < 5; i++) begin
      sample_edge(14);
      chk($sformatf("seq%0d_addr_a", i),  32'(last_aud_a), 32'(tbl[i].addr_a));
      chk($sformatf("seq%0d_ldata_a", i), 32'(ld_a),       32'(tbl[i].l_a));
      chk($sformatf("seq%0d_rdata_a", i), 32'(rr_a),       32'(tbl[i].l_a));
      chk($sformatf("seq%0d_ldata_b", i), 32'(ld_b),       32'(tbl[i].l_b));
      chk($sformatf("seq%0d_play_b", i),  32'(play_b),     32'(tbl[i].play_b));
      chk($sformatf("seq%0d_sd_a", i),    32'(sd_a),       32'(tbl[i].sd_a));
      chk($sformatf("seq%0d_sd_b", i),    32'(sd_b),       32'(tbl[i].sd_b));
      chk($sformatf("seq%0d_fetch_b", i), 32'(fetch_b),    32'(tbl[i].fetch_b));
    end
    chk("seq_overrun_a", 32'(ovr_a), 32'h0);

    // Sample request and general read in the same cycle: audio first
    adc_full = 1'b1;
    tick(2);
    rd_req_a = 1'b1; rd_addr = 20'h80000;
    tick(1);
    chk("arb_aud_first_addr", 32'(addr_a), 32'h1);
    chk("arb_aud_first_oe",   32'(oe_a),   32'h0);
    k = 1;
    while (!ack_a && k < 12) begin
      tick(1);
      k++;
    end
    chk("arb_ack_latency", 32'(k), 32'd6);
    rd_req_a = 1'b0;
    chk("arb_rd_data", 32'(rdd_a), 32'hBEEF);
    chk("arb_ldata",   32'(ld_a),  32'h1001);
    tick(1);
    chk("arb_ack_pulse", 32'(ack_a), 32'h0);
    adc_full = 1'b0;
    tick(3);

    // Reset in the middle of a general read with the strobe toggling
    snap_ack = ackc_a;
    rd_req_a = 1'b1; rd_addr = 20'h80000; adc_full = 1'b1;
    tick(1);
    Reset = 1'b0;
    #1;
    chk("mid_rst_ldata",   32'(ld_a),   32'h0);
    chk("mid_rst_rdata",   32'(rr_a),   32'h0);
    chk("mid_rst_rd_data", 32'(rdd_a),  32'h0);
    chk("mid_rst_addr",    32'(addr_a), 32'h0);
    chk("mid_rst_oe_n",    32'(oe_a),   32'h1);
    chk("mid_rst_playing", 32'(play_a), 32'h0);
    rd_req_a = 1'b0;
    repeat (4) begin
      adc_full = ~adc_full;
      tick(1);
    end
    adc_full = 1'b0;
    Reset = 1'b1;
    tick(4);
    chk("mid_rst_no_ack", 32'(ackc_a), 32'(snap_ack));
    pulse_play();
    sample_edge(14);
    chk("post_rst_ldata", 32'(ld_a),       32'h1000);
    chk("post_rst_rdata", 32'(rr_a),       32'h1000);
    chk("post_rst_addr",  32'(last_aud_a), 32'h0);
    chk("post_rst_ldata_b", 32'(ld_b),     32'h1000);

    // Two strobes inside one long general read on b
    snap_b = fetch_b;
    rd_req_b = 1'b1; rd_addr = 20'h80000; adc_full = 1'b1;
    tick(1);
    adc_full = 1'b0;
    tick(1);
    adc_full = 1'b1;
    tick(1);
    adc_full = 1'b0;
    k = 0;
    while (!ack_b && k < 20) begin
      tick(1);
      k++;
    end
    chk("ovr_ack_seen", 32'(ack_b), 32'h1);
    rd_req_b = 1'b0;
    chk("ovr_rd_data_b", 32'(rdd_b), 32'hBEEF);
    tick(14);
    chk("ovr_overrun_b", 32'(ovr_b),   32'h1);
    chk("ovr_one_fetch", 32'(fetch_b), 32'(snap_b + 1));
    chk("ovr_ldata_b",   32'(ld_b),    32'h1001);

    // Strobe with codec not initialised: no fetch now, none later
    snap_a = fetch_a; snap_b = fetch_b;
    INIT_FINISH = 1'b0;
    sample_edge(14);
    chk("noinit_fetch_a", 32'(fetch_a), 32'(snap_a));
    chk("noinit_fetch_b", 32'(fetch_b), 32'(snap_b));
    INIT_FINISH = 1'b1;
    tick(14);
    chk("noinit_no_pend_a", 32'(fetch_a), 32'(snap_a));
    chk("noinit_no_pend_b", 32'(fetch_b), 32'(snap_b));

    // play and stop together: stop wins
    play = 1'b1; stop = 1'b1;
    tick(1);
    play = 1'b0; stop = 1'b0;
    tick(1);
    chk("ps_playing_a", 32'(play_a), 32'h0);
    chk("ps_playing_b", 32'(play_b), 32'h0);
    chk("ps_ldata_a",   32'(ld_a),   32'h0);
    chk("ps_rdata_b",   32'(rr_b),   32'h0);
    snap_a = fetch_a;
    sample_edge(14);
    chk("ps_no_fetch", 32'(fetch_a), 32'(snap_a));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
